input_vc_buffer: RTL and testbench

Per-input-port virtual-channel buffer and route-computation stage of the NoC router, directly upstream of `in_out_allocator`. Stores incoming flits in one FIFO per VC and runs XY route computation on each packet's head flit. Drives per-VC switch requests and output-port selections to the allocator. On grant, pops the granted VC's flit toward the crossbar and returns a credit upstream. One instance per router input port.

---
 rtl/input_vc_buffer_pkg.sv | 42 ++++
 rtl/input_vc_buffer_fifo.sv | 48 ++++
 rtl/input_vc_buffer.sv | 134 +++++++++++++
 tb/tb_input_vc_buffer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/input_vc_buffer_pkg.sv
// Shared NoC router types: flit format, output ports, VC states and XY routing helpers.
package params_noc;

  localparam int VC_NUM_DEF     = 4;
  localparam int BUFF_DEPTH_DEF = 4;
  localparam int COORD_W        = 4;
  localparam int VC_ID_W        = 2;
  localparam int PAYLOAD_W      = 16;

  typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3} flit_type_t;
  typedef enum logic [2:0] {LOCAL = 3'd0, NORTH = 3'd1, SOUTH = 3'd2, EAST = 3'd3, WEST = 3'd4} port_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ROUTING = 2'd1, ACTIVE = 2'd2} vc_state_t;

  typedef struct packed {
    flit_type_t           flit_type;
    logic [VC_ID_W-1:0]   vc_id;
    logic [COORD_W-1:0]   dest_x;
    logic [COORD_W-1:0]   dest_y;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  // Dimension-ordered routing: resolve X first, then Y, else eject locally.
  function automatic port_t xy_route(input logic [COORD_W-1:0] dx, input logic [COORD_W-1:0] dy,
                                     input logic [COORD_W-1:0] cx, input logic [COORD_W-1:0] cy);
    port_t p;
    if (dx > cx)      p = EAST;
    else if (dx < cx) p = WEST;
    else if (dy > cy) p = NORTH;
    else if (dy < cy) p = SOUTH;
    else              p = LOCAL;
    return p;
  endfunction

  function automatic logic is_head(input flit_type_t t);
    return (t == HEAD) || (t == HEADTAIL);
  endfunction

  function automatic logic is_tail(input flit_type_t t);
    return (t == TAIL) || (t == HEADTAIL);
  endfunction

endpackage

// File: rtl/input_vc_buffer_fifo.sv
// Single-VC flit FIFO; pointers carry an extra wrap bit so full/empty come from pointer compare.
module vc_fifo
  import params_noc::*;
#(
  parameter int DEPTH = BUFF_DEPTH_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  flit_t din,
  output flit_t dout,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  flit_t          mem_r [DEPTH];
  logic [AW:0]    wr_ptr_r;
  logic [AW:0]    rd_ptr_r;
  logic           do_push_s;
  logic           do_pop_s;

  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign do_pop_s  = pop && !empty;
  // A full FIFO still accepts a write when its front leaves in the same cycle.
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Flit storage.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/input_vc_buffer.sv
// Router input port: per-VC flit FIFOs, XY route computation and grant-driven pop with credit return.
// Optional protocol checking is built when IVB_PROTOCOL_CHECK_EN is defined.
module input_vc_buffer
  import params_noc::*;
#(
  parameter int VC_NUM     = VC_NUM_DEF,
  parameter int BUFF_DEPTH = BUFF_DEPTH_DEF,
  parameter int X_CUR      = 0,
  parameter int Y_CUR      = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  flit_t               data_i,
  input  logic                valid_i,
  output logic [VC_NUM-1:0]   request_o,
  output port_t [VC_NUM-1:0]  out_port_o,
  input  logic [VC_NUM-1:0]   grant_i,
  output flit_t               flit_o,
  output logic                flit_valid_o,
  output logic [VC_NUM-1:0]   credit_o,
  output logic                error_o
);

  localparam logic [COORD_W-1:0] X_C = COORD_W'(X_CUR);
  localparam logic [COORD_W-1:0] Y_C = COORD_W'(Y_CUR);

  vc_state_t         state_r    [VC_NUM];
  vc_state_t         phase_s    [VC_NUM];
  port_t             out_port_r [VC_NUM];
  flit_t             front_s    [VC_NUM];
  logic [VC_NUM-1:0] push_s, pop_s, full_s, empty_s;
  logic              grant_onehot_s;
  flit_t             pop_flit_s;

  for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
    vc_fifo #(.DEPTH(BUFF_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s[g]),
      .pop   (pop_s[g]),
      .din   (data_i),
      .dout  (front_s[g]),
      .full  (full_s[g]),
      .empty (empty_s[g])
    );
    assign out_port_o[g] = out_port_r[g];
  end

  // Write steering, request generation and grant qualification.
  always_comb begin
    push_s         = '0;
    request_o      = '0;
    grant_onehot_s = (grant_i != '0) && ((grant_i & (grant_i - VC_NUM'(1))) == '0);
    for (int v = 0; v < VC_NUM; v++) begin
      push_s[v]    = valid_i && (data_i.vc_id == VC_ID_W'(v));
      request_o[v] = (state_r[v] == ACTIVE) && !empty_s[v];
      // An idle VC with a head at its front spends this cycle routing.
      phase_s[v]   = (state_r[v] == IDLE && !empty_s[v] && is_head(front_s[v].flit_type))
                     ? ROUTING : state_r[v];
    end
    pop_s = grant_onehot_s ? (grant_i & request_o) : '0;
  end

  // Select the popped VC's front flit; pop_s is at most one-hot.
  always_comb begin
    pop_flit_s = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      pop_flit_s = pop_s[v] ? front_s[v] : pop_flit_s;
    end
  end

  // Per-VC state machine and route latch.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (rst) begin
        state_r[v]    <= IDLE;
        out_port_r[v] <= LOCAL;
      end else begin
        case (phase_s[v])
          ROUTING: begin
            out_port_r[v] <= xy_route(front_s[v].dest_x, front_s[v].dest_y, X_C, Y_C);
            state_r[v]    <= ACTIVE;
          end
          ACTIVE:  if (pop_s[v] && is_tail(front_s[v].flit_type)) state_r[v] <= IDLE;
          IDLE:    state_r[v] <= IDLE;
          default: state_r[v] <= IDLE;
        endcase
      end
    end
  end

  // Crossbar flit and credit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_o       <= '0;
      flit_valid_o <= 1'b0;
      credit_o     <= '0;
    end else begin
      flit_valid_o <= |pop_s;
      credit_o     <= pop_s;
      if (|pop_s) flit_o <= pop_flit_s;
    end
  end

`ifdef IVB_PROTOCOL_CHECK_EN
  logic err_event_s;
  logic error_r;

  // Detect dropped writes, headless packets at an idle front and malformed grants.
  always_comb begin
    err_event_s = ((grant_i != '0) && !grant_onehot_s) || (|(grant_i & ~request_o));
    for (int v = 0; v < VC_NUM; v++) begin
      if (push_s[v] && full_s[v] && !pop_s[v]) begin
        err_event_s = 1'b1;
      end else if (state_r[v] == IDLE && !empty_s[v] && !is_head(front_s[v].flit_type)) begin
        err_event_s = 1'b1;
      end else begin
        err_event_s = err_event_s;
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)              error_r <= 1'b0;
    else if (err_event_s) error_r <= 1'b1;
  end

  assign error_o = error_r;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed bench for input_vc_buffer at mesh position (1,1) with four 4-deep VCs.
module tb_input_vc_buffer;
  import params_noc::*;

`ifdef IVB_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  flit_t        data_i;
  logic         valid_i;
  logic [3:0]   request_o;
  port_t [3:0]  out_port_o;
  logic [3:0]   grant_i;
  flit_t        flit_o;
  logic         flit_valid_o;
  logic [3:0]   credit_o;
  logic         error_o;

  int checks = 0;
  int errors = 0;
  flit_t pkt [4];

  input_vc_buffer #(.VC_NUM(4), .BUFF_DEPTH(4), .X_CUR(1), .Y_CUR(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .request_o    (request_o),
    .out_port_o   (out_port_o),
    .grant_i      (grant_i),
    .flit_o       (flit_o),
    .flit_valid_o (flit_valid_o),
    .credit_o     (credit_o),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  function automatic flit_t mk(input flit_type_t t, input int vc, input int dx, input int dy, input int pl);
    flit_t f;
    f.flit_type = t;
    f.vc_id     = VC_ID_W'(vc);
    f.dest_x    = COORD_W'(dx);
    f.dest_y    = COORD_W'(dy);
    f.payload   = PAYLOAD_W'(pl);
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input flit_t f);
    data_i  = f;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [3:0] g, input flit_t f);
    grant_i = g;
    tick();
    grant_i = 4'b0000;
    chk({tag, "_valid"}, 32'(flit_valid_o), 32'd1);
    chk({tag, "_flit"}, 32'(flit_o), 32'(f));
    chk({tag, "_credit"}, 32'(credit_o), 32'(g));
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; grant_i = 4'b0000; data_i = '0;
    tick(); tick();
    chk("rst_request", 32'(request_o), 32'd0);
    chk("rst_out_port", 32'(out_port_o), 32'd0);
    chk("rst_flit", 32'(flit_o), 32'd0);
    chk("rst_flit_valid", 32'(flit_valid_o), 32'd0);
    chk("rst_credit", 32'(credit_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    rst = 1'b0;
    tick();

    // HEADTAIL on VC0 to (3,1): EAST, request two cycles after the write.
    pkt[0] = mk(HEADTAIL, 0, 3, 1, 16'hA1);
    wr(pkt[0]);
    chk("t1_routing_no_req", 32'(request_o), 32'd0);
    tick();
    chk("t1_request", 32'(request_o), 32'b0001);
    chk("t1_port", 32'(out_port_o[0]), 32'(EAST));
    pop_chk("t1_pop", 4'b0001, pkt[0]);
    chk("t1_req_drop", 32'(request_o), 32'd0);
    tick();
    chk("t1_valid_pulse", 32'(flit_valid_o), 32'd0);
    chk("t1_credit_pulse", 32'(credit_o), 32'd0);

    // Four-flit packet on VC2 to (1,0): SOUTH, popped back-to-back.
    pkt[0] = mk(HEAD, 2, 1, 0, 16'h20);
    pkt[1] = mk(BODY, 2, 1, 0, 16'h21);
    pkt[2] = mk(BODY, 2, 1, 0, 16'h22);
    pkt[3] = mk(TAIL, 2, 1, 0, 16'h23);
    for (int i = 0; i < 4; i++) wr(pkt[i]);
    chk("t2_request", 32'(request_o), 32'b0100);
    chk("t2_port", 32'(out_port_o[2]), 32'(SOUTH));
    grant_i = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_flit", 32'(flit_o), 32'(pkt[i]));
      chk("t2_credit", 32'(credit_o), 32'b0100);
    end
    grant_i = 4'b0000;
    chk("t2_req_after_tail", 32'(request_o), 32'd0);

    // VC1 fill: rescued write with same-cycle pop, then a dropped write.
    for (int i = 0; i < 4; i++) wr(mk(i == 0 ? HEAD : BODY, 1, 1, 2, 16'h10 + i));
    chk("t3_port", 32'(out_port_o[1]), 32'(NORTH));
    data_i = mk(BODY, 1, 1, 2, 16'h14); valid_i = 1'b1; grant_i = 4'b0010;
    tick();
    valid_i = 1'b0; grant_i = 4'b0000;
    chk("t3_rescue_flit", 32'(flit_o), 32'(mk(HEAD, 1, 1, 2, 16'h10)));
    chk("t3_rescue_error", 32'(error_o), 32'd0);
    wr(mk(BODY, 1, 1, 2, 16'h15));
    tick();
    chk("t3_drop_error", 32'(error_o), 32'(EXP_ERR));
    for (int i = 1; i < 5; i++) pop_chk("t3_drain", 4'b0010, mk(BODY, 1, 1, 2, 16'h10 + i));
    chk("t3_empty_req", 32'(request_o), 32'd0);

    // Interleaved VC0 (to WEST) and VC3 (LOCAL) packets.
    wr(mk(HEAD, 0, 0, 1, 16'h40));
    wr(mk(HEAD, 3, 1, 1, 16'h30));
    wr(mk(TAIL, 0, 0, 1, 16'h41));
    wr(mk(TAIL, 3, 1, 1, 16'h31));
    chk("t4_request", 32'(request_o), 32'b1001);
    chk("t4_port0", 32'(out_port_o[0]), 32'(WEST));
    chk("t4_port3", 32'(out_port_o[3]), 32'(LOCAL));
    pop_chk("t4_pop_a", 4'b0001, mk(HEAD, 0, 0, 1, 16'h40));
    pop_chk("t4_pop_b", 4'b1000, mk(HEAD, 3, 1, 1, 16'h30));
    pop_chk("t4_pop_c", 4'b0001, mk(TAIL, 0, 0, 1, 16'h41));
    pop_chk("t4_pop_d", 4'b1000, mk(TAIL, 3, 1, 1, 16'h31));
    chk("t4_req_done", 32'(request_o), 32'd0);

    // Reset mid-packet on VC2, then a fresh packet routes normally.
    wr(mk(HEAD, 2, 2, 1, 16'h50));
    wr(mk(BODY, 2, 2, 1, 16'h51));
    chk("t5_pre_port", 32'(out_port_o[2]), 32'(EAST));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_request", 32'(request_o), 32'd0);
    chk("t5_port", 32'(out_port_o[2]), 32'(LOCAL));
    chk("t5_flit", 32'(flit_o), 32'd0);
    chk("t5_error", 32'(error_o), 32'd0);
    tick(); tick();
    chk("t5_flushed", 32'(request_o), 32'd0);
    wr(mk(HEADTAIL, 2, 1, 2, 16'h52));
    tick();
    chk("t5_new_req", 32'(request_o), 32'b0100);
    chk("t5_new_port", 32'(out_port_o[2]), 32'(NORTH));
    pop_chk("t5_new_pop", 4'b0100, mk(HEADTAIL, 2, 1, 2, 16'h52));

    // Multi-hot grant with VC0 and VC1 requesting is ignored.
    wr(mk(HEADTAIL, 0, 1, 1, 16'h60));
    wr(mk(HEADTAIL, 1, 1, 1, 16'h61));
    tick();
    chk("t6_request", 32'(request_o), 32'b0011);
    grant_i = 4'b0011;
    tick();
    grant_i = 4'b0000;
    chk("t6_no_valid", 32'(flit_valid_o), 32'd0);
    chk("t6_no_credit", 32'(credit_o), 32'd0);
    chk("t6_req_kept", 32'(request_o), 32'b0011);
    chk("t6_error", 32'(error_o), 32'(EXP_ERR));
    pop_chk("t6_pop", 4'b0010, mk(HEADTAIL, 1, 1, 1, 16'h61));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
